// File: rtl/l1_line_fill_ctrl.sv
// L1 cache bus-side controller: single reads, write-throughs and 256-beat line fills.
// Define BUS_TIMEOUT_EN to abort a bus beat left unacknowledged for TIMEOUT_CYC cycles.
module l1_line_fill_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_through_req,
   input  logic        read_req,
   input  logic        read_line_req,
   input  logic [3:0]  L1_size,
   input  logic [63:0] pa,
   input  logic [63:0] wt_data,
   output logic [63:0] line_data,
   output logic [10:0] addr_count,
   output logic        line_write,
   output logic        cache_entry_write,
   output logic        trans_rdy,
   output logic        bus_error,
   output logic        bus_req,
   output logic        bus_we,
   output logic [63:0] bus_addr,
   output logic [3:0]  bus_size,
   output logic [63:0] bus_wdata,
   input  logic [63:0] bus_rdata,
   input  logic        bus_ack,
   input  logic        bus_err
);

   typedef enum logic [2:0] {StIdle, StSingleRd, StSingleWr, StLine, StCommit, StRespGap} state_e;

   state_e      state_q, state_d;
   logic [7:0]  beat_q, beat_d, beat_nxt;
   logic [63:0] line_data_q, line_data_d;
   logic [10:0] addr_count_q, addr_count_d;
   logic        line_write_q, line_write_d;
   logic        cache_entry_write_q, cache_entry_write_d;
   logic        trans_rdy_q, trans_rdy_d;
   logic        bus_error_q, bus_error_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [63:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_size_q, bus_size_d;
   logic [63:0] bus_wdata_q, bus_wdata_d;
   logic        timeout, beat_fail, beat_ok;

`ifdef BUS_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        waiting;

   assign waiting = bus_req_q && !bus_ack && !bus_err;
   assign timeout = waiting && (tmo_q == 32'(TIMEOUT_CYC - 1));

   always_comb begin
      tmo_d = '0;
      if (waiting && !timeout) tmo_d = tmo_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) tmo_q <= '0;
      else      tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign timeout    = 1'b0;
`endif

   // An error (or timeout) on the same cycle as ack takes precedence.
   assign beat_fail = bus_req_q && (bus_err || timeout);
   assign beat_ok   = bus_req_q && bus_ack && !beat_fail;
   assign beat_nxt  = beat_q + 8'd1;

   always_comb begin
      state_d             = state_q;
      beat_d              = beat_q;
      line_data_d         = line_data_q;
      addr_count_d        = addr_count_q;
      line_write_d        = 1'b0;
      cache_entry_write_d = 1'b0;
      trans_rdy_d         = 1'b0;
      bus_error_d         = 1'b0;
      bus_req_d           = bus_req_q;
      bus_we_d            = bus_we_q;
      bus_addr_d          = bus_addr_q;
      bus_size_d          = bus_size_q;
      bus_wdata_d         = bus_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (read_line_req) begin
               state_d    = StLine;
               beat_d     = '0;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_addr_d = {pa[63:11], 11'b0};
               bus_size_d = 4'b1000;
            end else if (read_req) begin
               state_d    = StSingleRd;
               bus_req_d  = 1'b1;
               bus_we_d   = 1'b0;
               bus_addr_d = pa;
               bus_size_d = L1_size;
            end else if (write_through_req) begin
               state_d     = StSingleWr;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b1;
               bus_addr_d  = pa;
               bus_size_d  = L1_size;
               bus_wdata_d = wt_data;
            end
         end
         StSingleRd, StSingleWr: begin
            if (beat_fail) begin
               bus_req_d   = 1'b0;
               bus_error_d = 1'b1;
               state_d     = StRespGap;
            end else if (beat_ok) begin
               bus_req_d   = 1'b0;
               trans_rdy_d = 1'b1;
               state_d     = StRespGap;
               if (state_q == StSingleRd) line_data_d = bus_rdata;
            end
         end
         StLine: begin
            if (beat_fail) begin
               bus_req_d   = 1'b0;
               bus_error_d = 1'b1;
               state_d     = StRespGap;
            end else if (beat_ok) begin
               line_data_d  = bus_rdata;
               addr_count_d = {beat_q, 3'b000};
               line_write_d = 1'b1;
               if (beat_q == 8'hff) begin
                  bus_req_d = 1'b0;
                  state_d   = StCommit;
               end else begin
                  beat_d     = beat_nxt;
                  bus_addr_d = {bus_addr_q[63:11], beat_nxt, 3'b000};
               end
            end
         end
         StCommit: begin
            cache_entry_write_d = 1'b1;
            trans_rdy_d         = 1'b1;
            state_d             = StRespGap;
         end
         StRespGap: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q             <= StIdle;
         beat_q              <= '0;
         line_data_q         <= '0;
         addr_count_q        <= '0;
         line_write_q        <= 1'b0;
         cache_entry_write_q <= 1'b0;
         trans_rdy_q         <= 1'b0;
         bus_error_q         <= 1'b0;
         bus_req_q           <= 1'b0;
         bus_we_q            <= 1'b0;
         bus_addr_q          <= '0;
         bus_size_q          <= '0;
         bus_wdata_q         <= '0;
      end else begin
         state_q             <= state_d;
         beat_q              <= beat_d;
         line_data_q         <= line_data_d;
         addr_count_q        <= addr_count_d;
         line_write_q        <= line_write_d;
         cache_entry_write_q <= cache_entry_write_d;
         trans_rdy_q         <= trans_rdy_d;
         bus_error_q         <= bus_error_d;
         bus_req_q           <= bus_req_d;
         bus_we_q            <= bus_we_d;
         bus_addr_q          <= bus_addr_d;
         bus_size_q          <= bus_size_d;
         bus_wdata_q         <= bus_wdata_d;
      end
   end

   assign line_data         = line_data_q;
   assign addr_count        = addr_count_q;
   assign line_write        = line_write_q;
   assign cache_entry_write = cache_entry_write_q;
   assign trans_rdy         = trans_rdy_q;
   assign bus_error         = bus_error_q;
   assign bus_req           = bus_req_q;
   assign bus_we            = bus_we_q;
   assign bus_addr          = bus_addr_q;
   assign bus_size          = bus_size_q;
   assign bus_wdata         = bus_wdata_q;

endmodule
